sseg_scan: RTL
==============

# sseg_scan

Display scanner that produces the anode-select, character-select and clock-enable stream consumed by the 7-segment output stage. It converts the current steering gear (neutral/drive/reverse) and a backtrack request into a time-multiplexed, four-digit scan. It also generates the `ce` strobe, so the output stage samples only stable, fully updated selections. It sits between the steering control logic and the 7-segment output stage on the Basys3 top level.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit). Must be ≥2.
- `BT_HOLD_TICKS`, default 500: number of `ce` strobes that `backtrack_active` stays high after the request drops. Must be ≥1.

Ports:
- `clk`  in  1: system clock; all state is on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `gear`  in  2: 2'b00 neutral, 2'b01 drive, 2'b10 reverse, 2'b11 invalid.
- `backtrack_req`  in  1: level request for the backtrack indicator, sampled every clock.
- `an_sel`  out  4: active-low anode select, one-cold.
- `char_sel`  out  7: active-low segment pattern for the digit in `an_sel`.
- `ce`  out  1: one-cycle strobe, high in the cycle where `an_sel`/`char_sel` first hold new values.
- `backtrack_active`  out  1: backtrack indicator enable.

## Operation
- Segment constants:
  - T = 7'b0000111
  - D = 7'b0100001
  - N = 7'b0101011
  - R = 7'b0101111
  - BLANK = 7'b1111111
- Divider `cnt`:
  - Width is $clog2(REFRESH_DIV). It counts 0..REFRESH_DIV-1 and wraps to 0.
  - Call a "tick" the edge at which `cnt == REFRESH_DIV-1`.
- On each tick:
  - `an_sel` rotates 1110 → 1101 → 1011 → 0111 → 1110.
  - `ce` is registered to 1 for exactly one cycle.
  - `char_sel` is loaded for the new anode from the `gear` value sampled at that edge.
- `char_sel` rule for the new anode:
  - 1110 and gear = reverse: R.
  - 1101 and gear = neutral: N.
  - 1011 and gear = drive: D.
  - Any other combination, including gear = 2'b11: BLANK.
  - Anode 0111 is always BLANK, because the backtrack T is injected downstream.
- Backtrack hold counter `bt_cnt`:
  - Width is $clog2(BT_HOLD_TICKS+1).
  - Any cycle with `backtrack_req = 1`: `bt_cnt` ← BT_HOLD_TICKS. This is retriggerable.
  - Else, on a tick with `bt_cnt != 0`: `bt_cnt` decrements.
  - `backtrack_active` is registered as (next `bt_cnt` != 0).
- Simultaneous request and tick: the reload wins, with no decrement that cycle.
- A `gear` change between ticks has no effect until the next tick. No tearing occurs within a slot.

## Timing
- Reset values while `rst = 1`, applied immediately and asynchronously:
  - `cnt` = 0, `an_sel` = 4'b1110, `char_sel` = BLANK.
  - `ce` = 0, `bt_cnt` = 0, `backtrack_active` = 0.
- After reset release, the first tick is at the REFRESH_DIV-th rising edge.
  - `an_sel` = 1101 and `ce` = 1 in the following cycle.
  - `ce` is then 0 for REFRESH_DIV-1 cycles.
- `ce` period is exactly REFRESH_DIV cycles. `an_sel`, `char_sel` and `ce` always change on the same edge.
- Latency from `gear` to `char_sel` is up to 4·REFRESH_DIV cycles, i.e. until the matching anode comes round.
- `backtrack_req` rising: `backtrack_active` = 1 at the next edge, a 1-cycle latency.
- After `backtrack_req` falls, `backtrack_active` falls on the BT_HOLD_TICKS-th tick.
- Reset asserted mid-slot or mid-hold: all state returns to reset values. No partial `ce` pulse occurs.

## Test plan
- Reset/scan (REFRESH_DIV=4):
  - Release `rst` -> `an_sel` is 1110 for 4 cycles, then 1101, 1011, 0111, 1110.
  - `ce` is high exactly one cycle at each change and low otherwise.
- Gear decode (REFRESH_DIV=4, gear=01 held):
  - `char_sel` = 7'b0100001 only while `an_sel` = 1011; BLANK in all other slots.
  - Repeat with gear=00 -> N at 1101, and gear=10 -> R at 1110.
  - Repeat with gear=11 -> BLANK in all slots.
- Mid-slot gear change: switch `gear` 00→10 two cycles after a tick -> `char_sel` unchanged until the next tick; R appears on the first subsequent 1110 slot.
- Backtrack hold (REFRESH_DIV=4, BT_HOLD_TICKS=2): 1-cycle `backtrack_req` pulse -> `backtrack_active` is 1 from the next edge and drops at the 2nd tick after the pulse.
- Retrigger: second `backtrack_req` pulse coincident with a tick while active -> counter reloads to 2 with no decrement; the hold extends by 2 ticks from that point.
- Async reset mid-operation: assert `rst` between clock edges during the 1011 slot with `backtrack_active` = 1 -> outputs take reset values immediately; on release the scan restarts at 1110 with `cnt` = 0.

Source files
------------

// File: rtl/sseg_scan_if.sv
// Signal bundle between the steering control logic, the display scanner and the
// 7-segment output stage.
interface sseg_scan_if;
    logic [1:0] gear;
    logic       backtrack_req;
    logic [3:0] an_sel;
    logic [6:0] char_sel;
    logic       ce;
    logic       backtrack_active;

    modport master (
        output gear,
        output backtrack_req,
        input  an_sel,
        input  char_sel,
        input  ce,
        input  backtrack_active
    );

    modport slave (
        input  gear,
        input  backtrack_req,
        output an_sel,
        output char_sel,
        output ce,
        output backtrack_active
    );
endinterface

// File: rtl/sseg_scan.sv
// Four-digit 7-segment scanner: rotates the anode, decodes the steering gear for the
// selected digit, strobes ce on every slot change and stretches the backtrack request.
module sseg_scan #(
    parameter int REFRESH_DIV   = 100000,
    parameter int BT_HOLD_TICKS = 500
) (
    input  logic        clk,
    input  logic        rst,
    sseg_scan_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(BT_HOLD_TICKS + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BT_ONE   = BW'(1);
    localparam logic [BW-1:0] BT_LOAD  = BW'(BT_HOLD_TICKS);

    // Anode states of the scan, visited in this order
    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;

    localparam logic [1:0] GEAR_NEU = 2'b00;
    localparam logic [1:0] GEAR_DRV = 2'b01;
    localparam logic [1:0] GEAR_REV = 2'b10;

    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [CW-1:0] cnt_r;
    logic [3:0]    an_sel_r;
    logic [6:0]    char_sel_r;
    logic          ce_r;
    logic [BW-1:0] bt_cnt_r;
    logic          bt_active_r;

    logic          tick_s;
    logic [3:0]    an_next_s;
    logic [6:0]    char_next_s;
    logic [BW-1:0] bt_next_s;

    // Next anode and its character; the backtrack T for AN_3 is added by the output stage
    always_comb begin
        tick_s      = (cnt_r == CNT_LAST);
        an_next_s   = AN_0;
        char_next_s = SEG_BLANK;
        case (an_sel_r)
            AN_0:    an_next_s = AN_1;
            AN_1:    an_next_s = AN_2;
            AN_2:    an_next_s = AN_3;
            AN_3:    an_next_s = AN_0;
            default: an_next_s = AN_0;
        endcase
        case (an_next_s)
            AN_0: begin
                if (bus.gear == GEAR_REV) char_next_s = SEG_R;
                else                      char_next_s = SEG_BLANK;
            end
            AN_1: begin
                if (bus.gear == GEAR_NEU) char_next_s = SEG_N;
                else                      char_next_s = SEG_BLANK;
            end
            AN_2: begin
                if (bus.gear == GEAR_DRV) char_next_s = SEG_D;
                else                      char_next_s = SEG_BLANK;
            end
            default: char_next_s = SEG_BLANK;
        endcase
    end

    // Backtrack hold: a request reloads and beats a coincident tick's decrement
    always_comb begin
        bt_next_s = bt_cnt_r;
        if (bus.backtrack_req) begin
            bt_next_s = BT_LOAD;
        end else if (tick_s && (bt_cnt_r != BT_ZERO)) begin
            bt_next_s = bt_cnt_r - BT_ONE;
        end else begin
            bt_next_s = bt_cnt_r;
        end
    end

    // Divider, scan registers and backtrack state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            an_sel_r    <= AN_0;
            char_sel_r  <= SEG_BLANK;
            ce_r        <= 1'b0;
            bt_cnt_r    <= BT_ZERO;
            bt_active_r <= 1'b0;
        end else begin
            ce_r        <= tick_s;
            bt_cnt_r    <= bt_next_s;
            bt_active_r <= (bt_next_s != BT_ZERO);
            if (tick_s) begin
                cnt_r      <= CNT_ZERO;
                an_sel_r   <= an_next_s;
                char_sel_r <= char_next_s;
            end else begin
                cnt_r      <= cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.an_sel           = an_sel_r;
    assign bus.char_sel         = char_sel_r;
    assign bus.ce               = ce_r;
    assign bus.backtrack_active = bt_active_r;
endmodule
